// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/gnt + rvalid
// handshake, buffers responses in a prefetch FIFO and drives the IF/ID register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus_4_o,
  output logic [31:0] if_instr_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W-1:0] discard_next;
  logic [SUM_W-1:0] credit_used;
  logic             grant;
  logic             resp;
  logic             push;
  logic             pop;
  logic [31:0]      target_pc;

  // Credit-based request issue and response/discard accounting
  always_comb begin
    credit_used   = SUM_W'(count) + SUM_W'(inflight);
    imem_req_o    = !reset && !redirect_i && (credit_used < SUM_W'(FIFO_DEPTH));
    imem_addr_o   = fetch_pc;
    grant         = imem_req_o && imem_gnt_i;
    resp          = imem_rvalid_i && (inflight != '0);
    push          = resp && (discard == '0) && !redirect_i;
    pop           = !redirect_i && !stall_i && (count != '0);
    target_pc     = redirect_pc_i & ~32'h0000_0003;
    inflight_next = inflight + CNT_W'(grant) - CNT_W'(resp);
    discard_next  = discard;
    if (redirect_i) begin
      discard_next = inflight_next;
    end else if (resp && (discard != '0)) begin
      discard_next = discard - CNT_W'(1);
    end
  end

  // FIFO storage carries no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      inflight       <= '0;
      discard        <= '0;
      if_valid_o     <= 1'b0;
      if_pc_o        <= '0;
      if_pc_plus_4_o <= '0;
      if_instr_o     <= NOP_INSTR;
    end else begin
      inflight <= inflight_next;
      discard  <= discard_next;
      if (redirect_i) begin
        fetch_pc   <= target_pc;
        resp_pc    <= target_pc;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        if_valid_o <= 1'b0;
        if_instr_o <= NOP_INSTR;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        // Stall holds every IF/ID field; otherwise pop or emit a bubble
        if (pop) begin
          rd_ptr         <= rd_ptr + PTR_W'(1);
          if_valid_o     <= 1'b1;
          if_pc_o        <= fifo_pc[rd_ptr];
          if_pc_plus_4_o <= fifo_pc[rd_ptr] + 32'd4;
          if_instr_o     <= fifo_instr[rd_ptr];
        end else if (!stall_i) begin
          if_valid_o <= 1'b0;
          if_instr_o <= NOP_INSTR;
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with programmable latency and a
// queue-based reference of the fetch stream, plus a table of startup/stall vectors.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] SCRAMBLE = 32'h3C5A_96E1;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus_4_o;
  logic [31:0] if_instr_o;

  instr_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus_4_o(if_pc_plus_4_o),
    .if_instr_o    (if_instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mem_t;
  typedef struct { logic [31:0] addr; bit stale; } os_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } fe_t;
  typedef struct {
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mem_t mem_q[$];
  os_t  m_os[$];
  fe_t  m_fifo[$];

  logic [31:0] m_fetch;
  logic        m_v;
  logic [31:0] m_pc;
  logic [31:0] m_p4;
  logic [31:0] m_in;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_due = -1;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          data_is_addr = 1'b1;
  logic        req_seen;
  logic [31:0] addr_seen;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(bit st, bit rq, logic [31:0] a, bit v, logic [31:0] pc);
    vec_t r;
    r.stall = st; r.exp_req = rq; r.exp_addr = a; r.exp_valid = v; r.exp_pc = pc;
    return r;
  endfunction

  // One clock: drive at negedge, check request, update memory and model at the edge,
  // then check the IF/ID register 1 time unit after the edge.
  task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                      input int gnt_pct);
    bit          rv;
    bit          gnt;
    bit          exp_req;
    logic [31:0] rdata;
    os_t         o;
    fe_t         f;
    int          d;
    reset         = rst;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    rv            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata         = rv ? mem_q[0].data : $urandom();
    imem_rvalid_i = rv;
    imem_rdata_i  = rdata;
    gnt           = (int'($urandom_range(99)) < gnt_pct);
    imem_gnt_i    = gnt;
    #1;
    exp_req   = !rst && !rd && ((m_fifo.size() + m_os.size()) < DEPTH);
    req_seen  = imem_req_o;
    addr_seen = imem_addr_o;
    chk("imem_req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr_o, m_fetch);
    @(posedge clk);
    if (rv) void'(mem_q.pop_front());
    if (req_seen && gnt) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: addr_seen,
                        data: data_is_addr ? addr_seen : (addr_seen ^ SCRAMBLE), due: d});
    end
    if (rst) begin
      m_fetch = RESET_PC;
      m_os.delete();
      m_fifo.delete();
      m_v = 1'b0; m_pc = '0; m_p4 = '0; m_in = NOP;
    end else begin
      if (rd) begin
        m_v = 1'b0; m_in = NOP;
      end else if (!st) begin
        if (m_fifo.size() > 0) begin
          f = m_fifo.pop_front();
          m_v = 1'b1; m_pc = f.pc; m_p4 = f.pc + 32'd4; m_in = f.instr;
        end else begin
          m_v = 1'b0; m_in = NOP;
        end
      end
      if (rv && (m_os.size() > 0)) begin
        o = m_os.pop_front();
        if (!o.stale && !rd) m_fifo.push_back('{pc: o.addr, instr: rdata});
      end
      if (exp_req && gnt) begin
        m_os.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
      if (rd) begin
        foreach (m_os[i]) m_os[i].stale = 1'b1;
        m_fifo.delete();
        m_fetch = {rpc[31:2], 2'b00};
      end
    end
    cyc++;
    #1;
    chk("if_valid", 32'(if_valid_o), 32'(m_v));
    chk("if_pc", if_pc_o, m_pc);
    chk("if_pc_plus_4", if_pc_plus_4_o, m_p4);
    chk("if_instr", if_instr_o, m_in);
    @(negedge clk);
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    step(1'b1, 1'b0, 1'b0, '0, 0);
    step(1'b1, 1'b0, 1'b0, '0, 0);
    while ((mem_q.size() > 0) && (n < 20)) begin
      step(1'b1, 1'b0, 1'b0, '0, 0);
      n++;
    end
  endtask

  task automatic wait_valid(input string nm, input int budget, output int n);
    n = 0;
    while (!if_valid_o && (n < budget)) begin
      step(1'b0, 1'b0, 1'b0, '0, 100);
      n++;
    end
    chk(nm, 32'(if_valid_o), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    m_fetch = RESET_PC; m_v = 1'b0; m_pc = '0; m_p4 = '0; m_in = NOP;

    // Startup with zero-wait grant, 1-cycle rvalid, data = address, then 6-cycle stall
    tbl[0]  = mk(0, 1, 32'h0040_0000, 0, 32'h0000_0000);
    tbl[1]  = mk(0, 1, 32'h0040_0004, 0, 32'h0000_0000);
    tbl[2]  = mk(0, 1, 32'h0040_0008, 1, 32'h0040_0000);
    tbl[3]  = mk(0, 1, 32'h0040_000c, 1, 32'h0040_0004);
    tbl[4]  = mk(0, 1, 32'h0040_0010, 1, 32'h0040_0008);
    tbl[5]  = mk(0, 1, 32'h0040_0014, 1, 32'h0040_000c);
    tbl[6]  = mk(1, 1, 32'h0040_0018, 1, 32'h0040_000c);
    tbl[7]  = mk(1, 1, 32'h0040_001c, 1, 32'h0040_000c);
    tbl[8]  = mk(1, 0, 32'h0040_0020, 1, 32'h0040_000c);
    tbl[9]  = mk(1, 0, 32'h0040_0020, 1, 32'h0040_000c);
    tbl[10] = mk(1, 0, 32'h0040_0020, 1, 32'h0040_000c);
    tbl[11] = mk(1, 0, 32'h0040_0020, 1, 32'h0040_000c);
    tbl[12] = mk(0, 0, 32'h0040_0020, 1, 32'h0040_0010);
    tbl[13] = mk(0, 1, 32'h0040_0020, 1, 32'h0040_0014);
    tbl[14] = mk(0, 1, 32'h0040_0024, 1, 32'h0040_0018);
    tbl[15] = mk(0, 1, 32'h0040_0028, 1, 32'h0040_001c);
    tbl[16] = mk(0, 1, 32'h0040_002c, 1, 32'h0040_0020);

    @(negedge clk);
    do_reset();
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_pc4", if_pc_plus_4_o, 32'd0);
    chk("rst_instr", if_instr_o, NOP);
    chk("rst_req", 32'(imem_req_o), 32'd0);

    data_is_addr = 1'b1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, tbl[i].stall, 1'b0, '0, 100);
      chk("tbl_req", 32'(req_seen), 32'(tbl[i].exp_req));
      chk("tbl_addr", addr_seen, tbl[i].exp_addr);
      chk("tbl_valid", 32'(if_valid_o), 32'(tbl[i].exp_valid));
      chk("tbl_pc", if_pc_o, tbl[i].exp_pc);
      chk("tbl_instr", if_instr_o, tbl[i].exp_valid ? tbl[i].exp_pc : NOP);
    end
    data_is_addr = 1'b0;

    // Latency 3, two requests in flight, redirect to an unaligned target
    lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, 100);
    step(1'b0, 1'b0, 1'b0, '0, 100);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0101, 0);
    chk("rdr_req_low", 32'(req_seen), 32'd0);
    chk("rdr_bubble_v", 32'(if_valid_o), 32'd0);
    chk("rdr_bubble_i", if_instr_o, NOP);
    wait_valid("rdr_valid", 12, n);
    chk("rdr_latency", 32'(n), 32'd5);
    chk("rdr_pc", if_pc_o, 32'h0040_0100);
    chk("rdr_instr", if_instr_o, 32'h0040_0100 ^ SCRAMBLE);

    // Redirect together with stall: redirect wins
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, '0, 100);
    step(1'b0, 1'b1, 1'b1, 32'h0040_0800, 100);
    chk("rs_valid", 32'(if_valid_o), 32'd0);
    chk("rs_instr", if_instr_o, NOP);
    chk("rs_fetch_pc", imem_addr_o, 32'h0040_0800);
    wait_valid("rs_next_valid", 10, n);
    chk("rs_next_pc", if_pc_o, 32'h0040_0800);

    // Redirect in the same cycle as a response, grant withheld
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 100);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0a00, 0);
    chk("rr_req_low", 32'(req_seen), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0, 100);
    chk("rr_req_high", 32'(req_seen), 32'd1);
    chk("rr_addr", addr_seen, 32'h0040_0a00);
    wait_valid("rr_valid", 10, n);
    chk("rr_pc", if_pc_o, 32'h0040_0a00);

    // Reset with three requests in flight; late responses arrive after deassert
    lat_min = 4; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 100);
    step(1'b1, 1'b0, 1'b0, '0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 0);
    chk("late_valid", 32'(if_valid_o), 32'd0);
    wait_valid("late_first_valid", 20, n);
    chk("late_first_pc", if_pc_o, RESET_PC);

    // Address wrap at 2^32
    lat_min = 2; lat_max = 2;
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9, 100);
    wait_valid("wrap_valid", 12, n);
    chk("wrap_pc", if_pc_o, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 1'b0, '0, 100);
    step(1'b0, 1'b0, 1'b0, '0, 100);

    // Randomized traffic against the reference model
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : 32'($urandom());
      step($urandom_range(199) == 0, $urandom_range(99) < 25, $urandom_range(99) < 4,
           rpc, int'($urandom_range(100, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
